// File: rtl/data_merge_arbiter.sv
// data_merge_arbiter: merges three first-word-fall-through source FIFOs
// (FE RX, TDC, trigger) into one SRAM FIFO stream. Round-robin grants with
// a bounded burst per grant, a valid-tagged output register and a write
// counter.
module data_merge_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 16
) (
    input  logic                    BUS_CLK,
    input  logic                    BUS_RST_B,
    input  logic                    ENABLE,
    input  logic [2:0]              SRC_EMPTY,
    input  logic [3*DATA_WIDTH-1:0] SRC_DATA,
    output logic [2:0]              SRC_READ,
    output logic [DATA_WIDTH-1:0]   OUT_DATA,
    output logic [1:0]              OUT_SRC,
    output logic                    OUT_WRITE,
    input  logic                    OUT_FULL,
    output logic [31:0]             WORD_CNT,
    output logic                    BUSY
);

    localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    state_t                  state_r, state_nxt_s;
    logic [1:0]              gnt_r, gnt_nxt_s;
    logic [1:0]              last_r, last_nxt_s;
    logic [7:0]              burst_r, burst_nxt_s;
    logic                    valid_r;
    logic [DATA_WIDTH-1:0]   out_data_r;
    logic [1:0]              out_src_r;
    logic [31:0]             word_cnt_r;

    logic                    rd_en_s;
    logic                    out_write_s;
    logic                    can_accept_s;
    logic                    sel_empty_s;
    logic [DATA_WIDTH-1:0]   sel_data_s;
    logic [1:0]              cand1_s, cand2_s, cand3_s;
    logic [1:0]              pick_s;
    logic                    found_s;

    // Next index in round-robin order over the three sources.
    function automatic logic [1:0] inc_mod3(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : (idx + 2'd1);
    endfunction

    // Empty flag of a given source; an out-of-range index reads as empty.
    function automatic logic is_empty(input logic [1:0] idx, input logic [2:0] flags);
        logic res;
        case (idx)
            2'd0:    res = flags[0];
            2'd1:    res = flags[1];
            2'd2:    res = flags[2];
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    assign can_accept_s = !valid_r || !OUT_FULL;
    assign out_write_s  = valid_r && !OUT_FULL;

    // Select empty flag and data of the granted source.
    always_comb begin
        sel_empty_s = 1'b1;
        sel_data_s  = '0;
        case (gnt_r)
            2'd0: begin
                sel_empty_s = SRC_EMPTY[0];
                sel_data_s  = SRC_DATA[0*DATA_WIDTH +: DATA_WIDTH];
            end
            2'd1: begin
                sel_empty_s = SRC_EMPTY[1];
                sel_data_s  = SRC_DATA[1*DATA_WIDTH +: DATA_WIDTH];
            end
            2'd2: begin
                sel_empty_s = SRC_EMPTY[2];
                sel_data_s  = SRC_DATA[2*DATA_WIDTH +: DATA_WIDTH];
            end
            default: begin
                sel_empty_s = 1'b1;
                sel_data_s  = '0;
            end
        endcase
    end

    // Round-robin scan starting after the last served source.
    always_comb begin
        cand1_s = inc_mod3(last_r);
        cand2_s = inc_mod3(cand1_s);
        cand3_s = inc_mod3(cand2_s);
        pick_s  = 2'd0;
        found_s = 1'b0;
        if (!is_empty(cand1_s, SRC_EMPTY)) begin
            pick_s  = cand1_s;
            found_s = 1'b1;
        end else if (!is_empty(cand2_s, SRC_EMPTY)) begin
            pick_s  = cand2_s;
            found_s = 1'b1;
        end else if (!is_empty(cand3_s, SRC_EMPTY)) begin
            pick_s  = cand3_s;
            found_s = 1'b1;
        end else begin
            pick_s  = 2'd0;
            found_s = 1'b0;
        end
    end

    // FSM next-state, grant bookkeeping and read decision.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        last_nxt_s  = last_r;
        burst_nxt_s = burst_r;
        rd_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ENABLE && found_s) begin
                    gnt_nxt_s   = pick_s;
                    burst_nxt_s = 8'd0;
                    state_nxt_s = ST_SERVE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SERVE: begin
                rd_en_s = !sel_empty_s && (burst_r < MAX_BURST_C) && can_accept_s;
                if (rd_en_s) begin
                    burst_nxt_s = burst_r + 8'd1;
                end else begin
                    burst_nxt_s = burst_r;
                end
                // A burst that reaches its limit ends on its final read so no
                // extra cycle is spent; an empty source ends when seen empty.
                if (!ENABLE || sel_empty_s || (burst_r >= MAX_BURST_C) ||
                    (rd_en_s && ((burst_r + 8'd1) == MAX_BURST_C))) begin
                    state_nxt_s = ST_IDLE;
                    last_nxt_s  = gnt_r;
                end else begin
                    state_nxt_s = ST_SERVE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, grant, last-served and burst counter registers.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
        if (!BUS_RST_B) begin
            state_r <= ST_IDLE;
            gnt_r   <= 2'd0;
            last_r  <= 2'd2;
            burst_r <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            last_r  <= last_nxt_s;
            burst_r <= burst_nxt_s;
        end
    end

    // Valid-tagged output register: a load may coincide with a write-out.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
        if (!BUS_RST_B) begin
            valid_r    <= 1'b0;
            out_data_r <= '0;
            out_src_r  <= 2'd0;
        end else if (rd_en_s) begin
            valid_r    <= 1'b1;
            out_data_r <= sel_data_s;
            out_src_r  <= gnt_r;
        end else if (out_write_s) begin
            valid_r    <= 1'b0;
        end else begin
            valid_r    <= valid_r;
        end
    end

    // Count of words written to the SRAM FIFO, wrapping naturally.
    always_ff @(posedge BUS_CLK or negedge BUS_RST_B) begin
        if (!BUS_RST_B) begin
            word_cnt_r <= 32'd0;
        end else if (out_write_s) begin
            word_cnt_r <= word_cnt_r + 32'd1;
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    assign SRC_READ  = rd_en_s ? (3'b001 << gnt_r) : 3'b000;
    assign OUT_DATA  = out_data_r;
    assign OUT_SRC   = out_src_r;
    assign OUT_WRITE = out_write_s;
    assign WORD_CNT  = word_cnt_r;
    assign BUSY      = (state_r != ST_IDLE) || valid_r;

endmodule

// File: tb/tb_data_merge_arbiter.sv
// Directed bench for data_merge_arbiter: a table of FIFO-fill scenarios with
// hand-derived output order, plus hand-written reset and burst sequences.
module tb_data_merge_arbiter;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst_b;
    logic            enable;
    logic [2:0]      src_empty;
    logic [3*DW-1:0] src_data;
    logic [2:0]      src_read;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_src;
    logic            out_write;
    logic            out_full;
    logic [31:0]     word_cnt;
    logic            busy;

    data_merge_arbiter #(.DATA_WIDTH(DW), .MAX_BURST(16)) dut (
        .BUS_CLK   (clk),
        .BUS_RST_B (rst_b),
        .ENABLE    (enable),
        .SRC_EMPTY (src_empty),
        .SRC_DATA  (src_data),
        .SRC_READ  (src_read),
        .OUT_DATA  (out_data),
        .OUT_SRC   (out_src),
        .OUT_WRITE (out_write),
        .OUT_FULL  (out_full),
        .WORD_CNT  (word_cnt),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c[3];
        int fs;
        int fl;
        int en_off;
        int nrun;
        int rs[4];
        int rl[4];
    } vec_t;

    vec_t vt[6];

    int errors = 0;
    int checks = 0;
    int remaining[3];
    int rd_idx[3];
    int exp_idx[3];
    int exp_q[$];
    int exp_ptr;
    int wr_count;
    int rd_total;
    int cyc;
    int fs, fl, en_off;
    bit sb_on;
    logic [2:0]    prev_rd;
    logic [DW-1:0] hold_data;
    bit            last_wr;
    logic [1:0]    last_src;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic set_vec(input int i, input int c0, input int c1, input int c2,
                           input int f_s, input int f_l, input int eo, input int n,
                           input int s0, input int l0, input int s1, input int l1,
                           input int s2, input int l2, input int s3, input int l3);
        vt[i].c[0] = c0; vt[i].c[1] = c1; vt[i].c[2] = c2;
        vt[i].fs = f_s; vt[i].fl = f_l; vt[i].en_off = eo; vt[i].nrun = n;
        vt[i].rs[0] = s0; vt[i].rl[0] = l0; vt[i].rs[1] = s1; vt[i].rl[1] = l1;
        vt[i].rs[2] = s2; vt[i].rl[2] = l2; vt[i].rs[3] = s3; vt[i].rl[3] = l3;
    endtask

    task automatic drive_inputs();
        for (int k = 0; k < 3; k++) begin
            src_empty[k] = (remaining[k] == 0);
            src_data[k*DW +: DW] = 32'((k << 16) | rd_idx[k]);
        end
        out_full = (fl > 0) && (cyc >= fs) && (cyc < fs + fl);
        enable   = (en_off == 0) || (cyc < en_off);
    endtask

    task automatic tick();
        logic [2:0] rd;
        int s;
        @(negedge clk);
        rd = src_read;
        last_wr  = out_write;
        last_src = out_src;
        chk("read_onehot", 32'($countones(rd) <= 1), 32'd1);
        if (prev_rd != 3'b000 && !out_full)
            chk("latency", {31'b0, out_write}, 32'd1);
        if (fl > 0 && cyc == fs)
            hold_data = out_data;
        if (fl > 0 && cyc > fs && cyc < fs + fl) begin
            chk("hold_data", out_data, hold_data);
            chk("hold_read", {29'b0, rd}, 32'd0);
            chk("hold_write", {31'b0, out_write}, 32'd0);
        end
        if (out_write) begin
            wr_count++;
            if (sb_on && exp_ptr < exp_q.size()) begin
                s = exp_q[exp_ptr];
                chk("out_src", {30'b0, out_src}, 32'(s));
                chk("out_data", out_data, 32'((s << 16) | exp_idx[s]));
                exp_idx[s]++;
                exp_ptr++;
            end
        end
        prev_rd = rd;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (rd[k]) begin
                remaining[k]--;
                rd_idx[k]++;
                rd_total++;
            end
        end
        cyc++;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        #1;
        chk("rst_src_read", {29'b0, src_read}, 32'd0);
        chk("rst_out_write", {31'b0, out_write}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_src", {30'b0, out_src}, 32'd0);
        chk("rst_word_cnt", word_cnt, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        rst_b   = 1'b1;
        cyc     = 0;
        prev_rd = 3'b000;
        drive_inputs();
    endtask

    task automatic run_vec(input int i);
        int total;
        int n;
        fs = vt[i].fs; fl = vt[i].fl; en_off = vt[i].en_off;
        exp_q.delete();
        total = 0;
        for (int r = 0; r < vt[i].nrun; r++) begin
            for (int j = 0; j < vt[i].rl[r]; j++) exp_q.push_back(vt[i].rs[r]);
            total += vt[i].rl[r];
        end
        for (int k = 0; k < 3; k++) begin
            remaining[k] = vt[i].c[k];
            rd_idx[k]    = 0;
            exp_idx[k]   = 0;
        end
        exp_ptr = 0; wr_count = 0; rd_total = 0; sb_on = 1'b1;
        cyc = 0;
        do_reset();
        n = 0;
        while (exp_ptr < total && n < 400) begin
            tick();
            n++;
        end
        for (int j = 0; j < 12; j++) tick();
        chk($sformatf("v%0d_complete", i), 32'(exp_ptr), 32'(total));
        chk($sformatf("v%0d_writes", i), 32'(wr_count), 32'(total));
        chk($sformatf("v%0d_reads", i), 32'(rd_total), 32'(total));
        chk($sformatf("v%0d_word_cnt", i), word_cnt, 32'(total));
        chk($sformatf("v%0d_busy_end", i), {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int n;
        bit got;
        rst_b = 1'b0; enable = 1'b0; out_full = 1'b0;
        src_empty = 3'b111; src_data = '0;
        fs = 0; fl = 0; en_off = 0; cyc = 0; prev_rd = 3'b000;
        for (int k = 0; k < 3; k++) begin
            remaining[k] = 0; rd_idx[k] = 0; exp_idx[k] = 0;
        end
        hold_data = '0; last_wr = 1'b0; last_src = 2'd0;

        //        idx  c0  c1  c2  fs fl eo runs  (src,len) x4
        set_vec(0,  3,  3,  3,  0, 0, 0, 3,  0, 3,  1, 3,  2, 3,  0, 0);
        set_vec(1, 40,  1,  0,  0, 0, 0, 4,  0, 16, 1, 1,  0, 16, 0, 8);
        set_vec(2,  5,  0,  2,  4, 5, 0, 2,  0, 5,  2, 2,  0, 0,  0, 0);
        set_vec(3,  0,  0,  4,  0, 0, 0, 1,  2, 4,  0, 0,  0, 0,  0, 0);
        set_vec(4,  0,  2, 17,  0, 0, 0, 3,  1, 2,  2, 16, 2, 1,  0, 0);
        set_vec(5, 20, 20,  0, 20, 3, 0, 4,  0, 16, 1, 16, 0, 4,  1, 4);

        for (int i = 0; i < 6; i++) run_vec(i);

        // Dropping ENABLE mid-burst: one more read, pending word still written.
        set_vec(0, 10,  0,  0,  0, 0, 4, 1,  0, 4,  0, 0,  0, 0,  0, 0);
        run_vec(0);
        chk("en_off_src0_left", 32'(remaining[0]), 32'd6);

        // Asynchronous reset mid-burst, then the next grant goes to source 0.
        fs = 0; fl = 0; en_off = 0; sb_on = 1'b0;
        for (int k = 0; k < 3; k++) begin
            remaining[k] = 10; rd_idx[k] = 0;
        end
        cyc = 0;
        do_reset();
        for (int j = 0; j < 5; j++) tick();
        chk("mid_burst_busy", {31'b0, busy}, 32'd1);
        #2;
        do_reset();
        got = 1'b0;
        n = 0;
        while (!got && n < 20) begin
            tick();
            got = last_wr;
            n++;
        end
        chk("rst_regrant_seen", {31'b0, got}, 32'd1);
        chk("rst_regrant_src", {30'b0, last_src}, 32'd0);
        chk("rst_regrant_cnt", word_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
